// File: rtl/counter_sweep_pkg.sv
// Shared types and defaults for the triangle-sweep counter sequencer.
// State encoding, default widths and a busy-state decode helper.
package counter_sweep_pkg;

    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned SWEEP_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        UP,
        DOWN,
        DONE
    } sweep_state_e;

    function automatic logic is_busy(input sweep_state_e s);
        return (s == LOAD) || (s == UP) || (s == DOWN);
    endfunction

endpackage

// File: rtl/up_down_counter.sv
// 4-bit synchronous up/down counter with load; the sequencer drives its controls.
// Load takes priority over counting; both require en.
module up_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic             dir,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            if (ld) begin
                count_d = ld_val;
            end else if (dir) begin
                count_d = count_q + 1'b1;
            end else begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer driving an up/down counter: load lo, up to hi, down to lo, N times.
// Optional COUNTER_SWEEP_PAUSE_EN adds a pause input that freezes the run while busy.
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned SWEEP_W = SWEEP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef COUNTER_SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [SWEEP_W-1:0] cfg_sweeps,
    input  logic [WIDTH-1:0]   count_in,
    output logic               cnt_en,
    output logic               cnt_ld,
    output logic               cnt_dir,
    output logic [WIDTH-1:0]   cnt_ld_val,
    output logic               busy,
    output logic               done,
    output logic               err
);

    sweep_state_e     state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
    logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
    logic             err_q, err_d;

    logic             en_c, ld_c, dir_c;
    logic [WIDTH-1:0] ld_val_c;
    logic             paused;

`ifdef COUNTER_SWEEP_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        sweeps_d    = sweeps_q;
        sweep_cnt_d = sweep_cnt_q;
        err_d       = 1'b0;
        en_c        = 1'b0;
        ld_c        = 1'b0;
        dir_c       = 1'b0;
        ld_val_c    = '0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if ((cfg_lo <= cfg_hi) && (cfg_sweeps != '0)) begin
                        lo_d        = cfg_lo;
                        hi_d        = cfg_hi;
                        sweeps_d    = cfg_sweeps;
                        sweep_cnt_d = '0;
                        state_d     = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!paused) begin
                    en_c     = 1'b1;
                    ld_c     = 1'b1;
                    ld_val_c = lo_q;
                    state_d  = UP;
                end
            end
            UP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!paused) begin
                    // Bound is checked before enabling, so the count can never wrap.
                    if (count_in != hi_q) begin
                        en_c  = 1'b1;
                        dir_c = 1'b1;
                    end else begin
                        state_d = DOWN;
                    end
                end
            end
            DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!paused) begin
                    if (count_in != lo_q) begin
                        en_c = 1'b1;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                        state_d     = (sweep_cnt_d == sweeps_q) ? DONE : UP;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            sweeps_q    <= '0;
            sweep_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            sweeps_q    <= sweeps_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_q       <= err_d;
        end
    end

    // Outputs are forced low throughout the reset cycle, even mid-run.
    assign cnt_en     = en_c & ~rst;
    assign cnt_ld     = ld_c & ~rst;
    assign cnt_dir    = dir_c & ~rst;
    assign cnt_ld_val = rst ? '0 : ld_val_c;
    assign busy       = is_busy(state_q) & ~rst;
    assign done       = (state_q == DONE) & ~rst;
    assign err        = err_q & ~rst;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl wired to up_down_counter; directed cases plus random traffic.
// A queue of per-cycle expected controls, built from the sweep rules, is the reference.
module tb_counter_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause_eff;
    logic [3:0] cfg_lo, cfg_hi, cfg_sweeps;
    logic [3:0] count;
    logic       cnt_en, cnt_ld, cnt_dir;
    logic [3:0] cnt_ld_val;
    logic       busy, done, err;

`ifdef COUNTER_SWEEP_PAUSE_EN
    logic pause;
    assign pause_eff = pause;
`else
    assign pause_eff = 1'b0;
`endif

    always #5 clk = ~clk;

    counter_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef COUNTER_SWEEP_PAUSE_EN
        .pause      (pause),
`endif
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_sweeps (cfg_sweeps),
        .count_in   (count),
        .cnt_en     (cnt_en),
        .cnt_ld     (cnt_ld),
        .cnt_dir    (cnt_dir),
        .cnt_ld_val (cnt_ld_val),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    up_down_counter #(.WIDTH(4)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .ld     (cnt_ld),
        .dir    (cnt_dir),
        .ld_val (cnt_ld_val),
        .count  (count)
    );

    typedef struct packed {
        logic       en;
        logic       ld;
        logic       dir;
        logic [3:0] val;
        logic       fin;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    logic [3:0] count_m = '0;
    logic err_pend = 1'b0;

    logic       s_en, s_ld, s_busy, s_done, s_err;
    logic [3:0] s_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // One expected entry per busy cycle, then one for the DONE cycle.
    task automatic build(input int lo, input int hi, input int sw);
        exp_q.delete();
        exp_q.push_back('{en: 1'b1, ld: 1'b1, dir: 1'b0, val: 4'(lo), fin: 1'b0});
        for (int s = 0; s < sw; s++) begin
            for (int v = lo; v < hi; v++) exp_q.push_back('{1'b1, 1'b0, 1'b1, 4'd0, 1'b0});
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
            for (int v = hi; v > lo; v--) exp_q.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'd0, 1'b1});
    endtask

    function automatic logic model_busy();
        return (exp_q.size() != 0) && !exp_q[0].fin;
    endfunction

    task automatic step();
        exp_t h;
        logic e_en, e_ld, e_dir, e_busy, e_done, e_err, idle, new_err;
        logic [3:0] e_val;
        @(negedge clk);
        {e_en, e_ld, e_dir, e_busy, e_done, e_err} = '0;
        e_val = '0;
        h = '0;
        idle = (exp_q.size() == 0);
        if (!idle) h = exp_q[0];
        if (!rst) begin
            if (idle) begin
                e_err = err_pend;
            end else if (h.fin) begin
                e_done = 1'b1;
            end else begin
                e_busy = 1'b1;
                if (!abort && !pause_eff) begin
                    {e_en, e_ld, e_dir, e_val} = {h.en, h.ld, h.dir, h.val};
                end
            end
        end
        check("cnt_en", 32'(cnt_en), 32'(e_en));
        check("cnt_ld", 32'(cnt_ld), 32'(e_ld));
        check("cnt_dir", 32'(cnt_dir), 32'(e_dir));
        check("cnt_ld_val", 32'(cnt_ld_val), 32'(e_val));
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        check("count", 32'(count), 32'(count_m));
        {s_en, s_ld, s_busy, s_done, s_err, s_count} = {cnt_en, cnt_ld, busy, done, err, count};

        if (rst) begin
            exp_q.delete();
            count_m  = '0;
            err_pend = 1'b0;
        end else begin
            if (e_en) count_m = e_ld ? e_val : (e_dir ? count_m + 4'd1 : count_m - 4'd1);
            new_err = 1'b0;
            if (idle) begin
                if (start && !abort) begin
                    if (cfg_lo <= cfg_hi && cfg_sweeps != 0)
                        build(int'(cfg_lo), int'(cfg_hi), int'(cfg_sweeps));
                    else
                        new_err = 1'b1;
                end
            end else if (h.fin) begin
                void'(exp_q.pop_front());
            end else if (abort) begin
                exp_q.delete();
            end else if (!pause_eff) begin
                void'(exp_q.pop_front());
            end
            err_pend = new_err;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic kick(input int lo, input int hi, input int sw);
        cfg_lo = 4'(lo); cfg_hi = 4'(hi); cfg_sweeps = 4'(sw);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int done_at, busy_n, done_n, wraps;
    logic [3:0] prev;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_lo = '0; cfg_hi = '0; cfg_sweeps = '0;
`ifdef COUNTER_SWEEP_PAUSE_EN
        pause = 1'b0;
`endif
        @(posedge clk); #1;
        reset_dut();
        check("reset_busy", 32'(s_busy), 32'd0);
        check("reset_en", 32'(s_en), 32'd0);

        // lo=2 hi=5 x1: counts 2,3,4,5,5,4,3,2 then done in cycle 10
        kick(2, 5, 1);
        done_at = -1; busy_n = 0;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (s_busy) busy_n++;
            if (s_done && done_at < 0) done_at = c;
            if (c == 2) check("seq_c2", 32'(s_count), 32'd2);
            if (c == 5) check("seq_c5_dwell", 32'(s_count), 32'd5);
            if (c == 6) check("seq_c6", 32'(s_count), 32'd5);
            if (c == 9) check("seq_c9", 32'(s_count), 32'd2);
        end
        check("seq_done_cycle", 32'(done_at), 32'd10);
        check("seq_busy_cycles", 32'(busy_n), 32'd9);

        // Invalid configs: lo>hi, then sweeps=0
        kick(7, 3, 1);
        step();
        check("err_lo_gt_hi", 32'(s_err), 32'd1);
        check("err_no_ld", 32'(s_ld | s_en | s_busy), 32'd0);
        kick(1, 2, 0);
        step();
        check("err_sweeps0", 32'(s_err), 32'd1);
        step();
        check("err_one_cycle", 32'(s_err), 32'd0);

        // lo=hi=4 x3: 1 load + 6 dwell cycles
        kick(4, 4, 3);
        done_at = -1; busy_n = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (s_busy) busy_n++;
            if (s_done && done_at < 0) done_at = c;
            if (c >= 2 && c <= 8) check("flat_count", 32'(s_count), 32'd4);
        end
        check("flat_busy", 32'(busy_n), 32'd7);
        check("flat_done_cycle", 32'(done_at), 32'd8);

        // Full range x2: never wraps, exactly one done
        kick(0, 15, 2);
        done_n = 0; wraps = 0; prev = s_count;
        for (int c = 1; c <= 80; c++) begin
            step();
            if ((prev == 4'd15 && s_count == 4'd0) || (prev == 4'd0 && s_count == 4'd15)) wraps++;
            prev = s_count;
            if (s_done) done_n++;
        end
        check("full_wraps", 32'(wraps), 32'd0);
        check("full_dones", 32'(done_n), 32'd1);

        // Abort in UP at count 3
        kick(1, 6, 2);
        for (int c = 1; c <= 3; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_at3", 32'(s_count), 32'd3);
        step();
        check("abort_idle", 32'(s_busy), 32'd0);
        check("abort_hold", 32'(s_count), 32'd3);
        step();
        check("abort_no_done", 32'(s_done), 32'd0);

        // rst mid-DOWN (cycle 7, count 4)
        kick(2, 5, 1);
        for (int c = 1; c <= 6; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outs", 32'({s_en, s_ld, s_busy, s_done, s_err}), 32'd0);
        done_n = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_done | s_err) done_n++;
        end
        check("rst_no_done", 32'(done_n), 32'd0);
        check("rst_count", 32'(s_count), 32'd0);

`ifdef COUNTER_SWEEP_PAUSE_EN
        // Pause 3 cycles at count 4 in UP; done slips from cycle 12 to 15
        kick(2, 6, 1);
        done_at = -1;
        for (int c = 1; c <= 16; c++) begin
            pause = (c >= 4 && c <= 6);
            step();
            if (c >= 4 && c <= 7) check("pause_hold", 32'(s_count), 32'd4);
            if (c == 5) check("pause_busy", 32'(s_busy), 32'd1);
            if (s_done && done_at < 0) done_at = c;
        end
        pause = 1'b0;
        check("pause_done_cycle", 32'(done_at), 32'd15);
`endif

        // Random traffic; cfg changes every cycle to exercise latching
        for (int i = 0; i < 15000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            cfg_lo     = 4'($urandom);
            cfg_hi     = 4'($urandom);
            cfg_sweeps = 4'($urandom_range(0, 5));
            start      = ($urandom_range(0, 3) == 0);
            abort      = model_busy() && ($urandom_range(0, 59) == 0);
`ifdef COUNTER_SWEEP_PAUSE_EN
            pause      = ($urandom_range(0, 5) == 0);
`endif
            step();
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
